// File: rtl/breakout_pkg.sv
// breakout_pkg: shared widths and engine state encoding for the breakout block-state logic.
package breakout_pkg;
    localparam int NUM_COLS = 13;
    localparam int ROW_W    = 4;
    localparam int COL_W    = 4;
    localparam int COUNT_W  = 8;
    typedef enum logic [2:0] {INIT, IDLE, SEEK, CHECK, RESP} state_t;
endpackage

// File: rtl/line_popcount.sv
// line_popcount: combinational brick count of one store line.
module line_popcount import breakout_pkg::*; (
    input  logic [NUM_COLS-1:0] bits,
    output logic [3:0]          count
);
    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_COLS; i++) count = count + 4'(bits[i]);
    end
endmodule

// File: rtl/block_hit_engine.sv
// block_hit_engine: read-modify-write hit client for the rotating block-state line store.
// BLOCK_HIT_COUNT_EN adds the post-reset brick scan, blocks_left and all_clear.
module block_hit_engine import breakout_pkg::*; #(
    parameter int NUM_ROWS = 15
) (
    input  logic                clk,
    input  logic                nRst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ROW_W-1:0]    req_row,
    input  logic [COL_W-1:0]    req_col,
    output logic                resp_valid,
    output logic                resp_hit,
    input  logic [NUM_COLS-1:0] line,
    output logic [NUM_COLS-1:0] new_line,
    output logic                write_line,
    output logic                next_line,
    output logic [COUNT_W-1:0]  blocks_left,
    output logic                all_clear
);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);
`ifdef BLOCK_HIT_COUNT_EN
    localparam state_t RST_STATE = INIT;
`else
    localparam state_t RST_STATE = IDLE;
`endif

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   ptr_q, ptr_d, row_q, row_d, ptr_inc;
    logic [COL_W-1:0]   col_q, col_d;
    logic               hit_q, hit_d;

    assign ptr_inc    = (ptr_q == LAST_ROW) ? '0 : ptr_q + ROW_W'(1);
    assign req_ready  = state_q == IDLE;
    assign resp_valid = state_q == RESP;
    assign resp_hit   = resp_valid && hit_q;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= RST_STATE;
            ptr_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            row_q   <= row_d;
            col_q   <= col_d;
            hit_q   <= hit_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        row_d      = row_q;
        col_d      = col_q;
        hit_d      = hit_q;
        next_line  = 1'b0;
        write_line = 1'b0;
        case (state_q)
            INIT: begin
                // Reset state is INIT, so the strobe must stay low while nRst is held.
                next_line = nRst;
                ptr_d     = ptr_inc;
                if (ptr_q == LAST_ROW) state_d = IDLE;
            end
            IDLE: if (req_valid) begin
                row_d   = req_row;
                col_d   = req_col;
                hit_d   = 1'b0;
                state_d = (req_row > LAST_ROW || req_col > LAST_COL) ? RESP : SEEK;
            end
            SEEK: if (ptr_q != row_q) begin
                next_line = 1'b1;
                ptr_d     = ptr_inc;
            end else begin
                state_d = CHECK;
            end
            CHECK: begin
                write_line = line[col_q];
                hit_d      = line[col_q];
                state_d    = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        new_line = write_line ? (line & ~(NUM_COLS'(1) << col_q)) : '0;
    end

`ifdef BLOCK_HIT_COUNT_EN
    logic [3:0]         line_bits;
    logic [COUNT_W-1:0] count_q, count_d;

    line_popcount u_popcount (.bits(line), .count(line_bits));

    always_comb count_d = (state_q == INIT) ? count_q + COUNT_W'(line_bits)
                        : (write_line && count_q != '0) ? count_q - COUNT_W'(1) : count_q;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) count_q <= '0;
        else       count_q <= count_d;
    end

    assign blocks_left = count_q;
    assign all_clear   = state_q != INIT && count_q == '0;
`else
    assign blocks_left = '0;
    assign all_clear   = 1'b0;
`endif
endmodule

// File: tb/tb_block_hit_engine.sv
// tb_block_hit_engine: scoreboard bench for block_hit_engine against a behavioural line store.
// Works with or without BLOCK_HIT_COUNT_EN.
module tb_block_hit_engine;
`ifdef BLOCK_HIT_COUNT_EN
    localparam bit CNT = 1'b1;
`else
    localparam bit CNT = 1'b0;
`endif

    logic        clk = 1'b0, nRst = 1'b0, req_valid = 1'b0;
    logic [3:0]  req_row = '0, req_col = '0;
    logic        req_ready, resp_valid, resp_hit, write_line, next_line, all_clear;
    logic [12:0] line, new_line;
    logic [7:0]  blocks_left;

    block_hit_engine #(.NUM_ROWS(15)) dut (
        .clk(clk), .nRst(nRst), .req_valid(req_valid), .req_ready(req_ready),
        .req_row(req_row), .req_col(req_col), .resp_valid(resp_valid), .resp_hit(resp_hit),
        .line(line), .new_line(new_line), .write_line(write_line), .next_line(next_line),
        .blocks_left(blocks_left), .all_clear(all_clear)
    );

    always #5 clk = ~clk;

    // Behavioural store: rows 0..6 full, rows 7..14 empty after reset.
    logic [12:0] mem [15];
    logic [3:0]  scur;
    assign line = mem[scur];
    always @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            for (int i = 0; i < 15; i++) mem[i] <= (i < 7) ? 13'h1FFF : 13'h0000;
            scur <= '0;
        end else begin
            if (write_line) mem[scur] <= new_line;
            if (next_line) scur <= (scur == 4'd14) ? 4'd0 : scur + 4'd1;
        end
    end

    typedef struct {
        logic        hit;
        int          lat;
        int          nl;
        int          wl;
        logic [12:0] nline;
        int          left;
    } exp_t;
    exp_t sb[$];

    logic [12:0] rb [15];
    int rptr, rcnt;
    int checks = 0, failures = 0;

    task automatic ref_reset();
        rcnt = 0;
        for (int i = 0; i < 15; i++) begin
            rb[i] = (i < 7) ? 13'h1FFF : 13'h0000;
            rcnt += $countones(rb[i]);
        end
        rptr = 0;
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!req_ready) begin
            failures++;
            $display("FAIL ready_timeout got=%0b exp=1", req_ready);
        end
    endtask

    task automatic query(input int row, input int col);
        exp_t e;
        int d, cyc, nl, wl, bad;
        logic [12:0] nw;
        logic hit, got, rdy1;
        bit valid;
        wait_ready();
        valid   = row < 15 && col < 13;
        d       = valid ? (row - rptr + 15) % 15 : 0;
        e.hit   = valid ? rb[row][col] : 1'b0;
        e.lat   = valid ? d + 3 : 1;
        e.nl    = d;
        e.wl    = e.hit ? 1 : 0;
        e.nline = e.hit ? (rb[row] & ~(13'd1 << col)) : 13'h0;
        if (e.hit) begin
            rb[row] = e.nline;
            rcnt--;
        end
        if (valid) rptr = row;
        e.left = CNT ? rcnt : 0;
        sb.push_back(e);
        req_valid = 1'b1;
        req_row   = row[3:0];
        req_col   = col[3:0];
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rdy1 = req_ready;
        cyc = 1; nl = 0; wl = 0; bad = 0; nw = '0; got = 1'b0; hit = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (next_line) nl++;
            if (write_line) begin
                wl++;
                nw = new_line;
            end
            if ((write_line && next_line) || (!write_line && new_line != 13'h0)) bad++;
            if (resp_valid) begin
                got = 1'b1;
                hit = resp_hit;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        e = sb.pop_front();
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL resp_timeout row=%0d col=%0d got=none exp=resp at cycle %0d", row, col, e.lat);
        end else begin
            checks += 7;
            if (hit !== e.hit) begin failures++; $display("FAIL resp_hit row=%0d col=%0d got=%0b exp=%0b", row, col, hit, e.hit); end
            if (cyc != e.lat) begin failures++; $display("FAIL latency row=%0d col=%0d got=%0d exp=%0d", row, col, cyc, e.lat); end
            if (nl != e.nl) begin failures++; $display("FAIL next_line_count row=%0d col=%0d got=%0d exp=%0d", row, col, nl, e.nl); end
            if (wl != e.wl) begin failures++; $display("FAIL write_line_count row=%0d col=%0d got=%0d exp=%0d", row, col, wl, e.wl); end
            if (nw !== e.nline) begin failures++; $display("FAIL new_line row=%0d col=%0d got=%h exp=%h", row, col, nw, e.nline); end
            if (bad != 0) begin failures++; $display("FAIL strobe_rules row=%0d col=%0d got=%0d violations exp=0", row, col, bad); end
            if (blocks_left !== 8'(e.left)) begin failures++; $display("FAIL blocks_left row=%0d col=%0d got=%0d exp=%0d", row, col, blocks_left, e.left); end
        end
        checks++;
        if (rdy1 !== 1'b0) begin failures++; $display("FAIL ready_busy row=%0d col=%0d got=%0b exp=0", row, col, rdy1); end
    endtask

    // Asserts nRst on the next falling edge, checks reset values, then times the scan.
    task automatic do_reset();
        int c = 0, n = 0, rv = 0;
        @(negedge clk);
        nRst = 1'b0;
        req_valid = 1'b0;
        ref_reset();
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_hit, write_line, next_line, new_line, blocks_left, all_clear} !== {!CNT, 26'd0}) begin
            failures++;
            $display("FAIL reset_values got=%b%b%b%b%b_%h_%0d_%b exp=%b0000_0000_0_0",
                     req_ready, resp_valid, resp_hit, write_line, next_line, new_line, blocks_left, all_clear, !CNT);
        end
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) rv++;
        end
        nRst = 1'b1;
        #1;
        while (!req_ready && c < 40) begin
            if (next_line) n++;
            if (resp_valid) rv++;
            c++;
            @(negedge clk);
        end
        checks += 5;
        if (c != (CNT ? 15 : 0)) begin failures++; $display("FAIL init_cycles got=%0d exp=%0d", c, CNT ? 15 : 0); end
        if (n != (CNT ? 15 : 0)) begin failures++; $display("FAIL init_next_line got=%0d exp=%0d", n, CNT ? 15 : 0); end
        if (blocks_left !== 8'(CNT ? rcnt : 0)) begin failures++; $display("FAIL init_blocks_left got=%0d exp=%0d", blocks_left, CNT ? rcnt : 0); end
        if (scur != 4'd0) begin failures++; $display("FAIL init_ptr got=%0d exp=0", scur); end
        if (rv != 0) begin failures++; $display("FAIL reset_resp got=%0d strobes exp=0", rv); end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_hit();
        query(0, 0);
    endtask

    task automatic test_empty_row();
        query(14, 3);
    endtask

    task automatic test_wrap();
        query(5, 0);
        query(2, 2);
        checks++;
        if (line !== 13'h1FFB) begin failures++; $display("FAIL row2_readback got=%h exp=1ffb", line); end
    endtask

    task automatic test_invalid();
        query(15, 0);
        query(0, 13);
        query(15, 15);
    endtask

    task automatic test_repeat();
        query(2, 2);
        query(5, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) query(int'($urandom_range(0, 15)), int'($urandom_range(0, 13)));
    endtask

    task automatic test_reset_mid();
        int row;
        wait_ready();
        row = (rptr + 5) % 15;
        req_valid = 1'b1;
        req_row   = 4'(row);
        req_col   = 4'd0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (next_line !== 1'b1) begin failures++; $display("FAIL mid_seek got=%0b exp=1", next_line); end
        do_reset();
        query(0, 0);
    endtask

    task automatic test_clear_all();
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 13; c++)
                if (rb[r][c]) query(r, c);
        @(negedge clk);
        checks += 2;
        if (blocks_left !== 8'd0) begin failures++; $display("FAIL clear_blocks_left got=%0d exp=0", blocks_left); end
        if (all_clear !== CNT) begin failures++; $display("FAIL all_clear got=%0b exp=%0b", all_clear, CNT); end
        query(3, 4);
    endtask

    initial begin
        ref_reset();
        #2;
        test_reset();
        test_hit();
        test_empty_row();
        test_wrap();
        test_invalid();
        test_repeat();
        test_back_to_back();
        test_reset_mid();
        test_clear_all();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
